// File: rtl/ibuffer_dequeuer_pkg.sv
// Shared sizing and types for the instruction-buffer head parse/select stage.
// The buffer head is 16 parcel slots deep, and up to 4 instructions leave it per cycle.
package ibuffer_dequeuer_pkg;

    localparam int IBUF_PARCELS = 16;
    localparam int IBUF_IDX_W   = 4;
    localparam int IBUF_COUNT_W = 5;
    localparam int DEQ_WAYS     = 4;

    localparam logic [IBUF_IDX_W-1:0] IDX_NONE = '1;

    typedef logic [IBUF_PARCELS-1:0][IBUF_COUNT_W-1:0] count_vec_t;
    typedef logic [DEQ_WAYS-1:0][IBUF_IDX_W-1:0]       idx_by_way_t;

    // Second-parcel slot: the next slot, or none when the start sits in the last slot.
    function automatic logic [IBUF_IDX_W-1:0] second_of(input logic [IBUF_IDX_W-1:0] first);
        return (first == IDX_NONE) ? IDX_NONE : first + 1'b1;
    endfunction

endpackage

// File: rtl/ibuffer_way_pick.sv
// Lowest-set priority encoder: reports the first slot whose hit bit is set.
// When no hit bit is set, the index reads as all-ones.
module ibuffer_way_pick
    import ibuffer_dequeuer_pkg::*;
(
    input  logic [IBUF_PARCELS-1:0] hit_vec,
    output logic                    found,
    output logic [IBUF_IDX_W-1:0]   idx
);

    always_comb begin
        found = 1'b0;
        idx   = IDX_NONE;
        for (int i = IBUF_PARCELS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                found = 1'b1;
                idx   = IBUF_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ibuffer_dequeuer.sv
// Combinational parse of the instruction-buffer head into compressed and uncompressed
// instructions. Selects up to DEQ_WAYS complete instructions in slot order for decode.
module ibuffer_dequeuer
    import ibuffer_dequeuer_pkg::*;
(
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [IBUF_PARCELS-1:0] valid_vec,
    input  logic [IBUF_PARCELS-1:0] uncompressed_vec,
    input  logic [IBUF_PARCELS-1:0] redirect_vec,
    output count_vec_t              count_vec,
    output logic [IBUF_PARCELS-1:0] deqing_vec,
    output logic [DEQ_WAYS-1:0]     valid_by_way,
    output idx_by_way_t             first_idx_by_way,
    output idx_by_way_t             second_idx_by_way
);

    // No state is held here; clock and reset exist only so every stage has the same ports.
    logic unused_ports;
    assign unused_ports = CLK ^ nRST;

    logic [IBUF_PARCELS:0]          valid_ext;
    logic [IBUF_PARCELS-1:0]        is_start;
    logic [IBUF_PARCELS-1:0]        is_complete;
    logic [IBUF_PARCELS-1:0]        owned;
    logic [IBUF_COUNT_W-1:0]        running;
    logic                           consumed;
    count_vec_t                     count_c;
    logic [DEQ_WAYS-1:0][IBUF_PARCELS-1:0] hit_by_way;

    // A start never looks past slot 15: the padded zero makes the missing slot 16 read as invalid.
    always_comb begin
        valid_ext   = {1'b0, valid_vec};
        is_start    = '0;
        is_complete = '0;
        count_c     = '0;
        running     = '0;
        consumed    = 1'b0;
        for (int i = 0; i < IBUF_PARCELS; i++) begin
            is_start[i]    = valid_vec[i] & ~consumed;
            is_complete[i] = is_start[i] &
                             (~uncompressed_vec[i] | valid_ext[i+1] | redirect_vec[i]);
            if (is_complete[i]) begin
                running = running + 1'b1;
            end
            count_c[i] = running;
            consumed   = is_start[i] & uncompressed_vec[i];
        end
    end

    assign count_vec = count_c;

    // The running count steps only on complete starts, so exactly one slot matches each way.
    always_comb begin
        hit_by_way = '0;
        for (int w = 0; w < DEQ_WAYS; w++) begin
            for (int i = 0; i < IBUF_PARCELS; i++) begin
                hit_by_way[w][i] = is_complete[i] &&
                                   (count_c[i] == IBUF_COUNT_W'(w + 1));
            end
        end
    end

    for (genvar w = 0; w < DEQ_WAYS; w++) begin : g_way
        ibuffer_way_pick u_pick (
            .hit_vec (hit_by_way[w]),
            .found   (valid_by_way[w]),
            .idx     (first_idx_by_way[w])
        );
        assign second_idx_by_way[w] = valid_by_way[w] ? second_of(first_idx_by_way[w])
                                                       : IDX_NONE;
    end

    // A second half leaves only together with its owning start, and only when it is valid.
    always_comb begin
        owned      = '0;
        deqing_vec = '0;
        for (int i = 0; i < IBUF_PARCELS; i++) begin
            owned[i]      = is_complete[i] && (count_c[i] <= IBUF_COUNT_W'(DEQ_WAYS));
            deqing_vec[i] = owned[i];
            if (i > 0) begin
                if (owned[i-1] && uncompressed_vec[i-1] && valid_vec[i]) begin
                    deqing_vec[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ibuffer_dequeuer.sv
// Self-checking bench for ibuffer_dequeuer.
// Directed and random parcel patterns are scored against a pointer-walking reference model.
module tb_ibuffer_dequeuer;

  typedef struct packed {
    logic [15:0][4:0] cnt;
    logic [15:0]      deq;
    logic [3:0]       vbw;
    logic [3:0][3:0]  first;
    logic [3:0][3:0]  second;
  } exp_t;

  logic              CLK;
  logic              nRST;
  logic [15:0]       valid_vec;
  logic [15:0]       uncompressed_vec;
  logic [15:0]       redirect_vec;
  logic [15:0][4:0]  count_vec;
  logic [15:0]       deqing_vec;
  logic [3:0]        valid_by_way;
  logic [3:0][3:0]   first_idx_by_way;
  logic [3:0][3:0]   second_idx_by_way;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ibuffer_dequeuer dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .valid_vec         (valid_vec),
    .uncompressed_vec  (uncompressed_vec),
    .redirect_vec      (redirect_vec),
    .count_vec         (count_vec),
    .deqing_vec        (deqing_vec),
    .valid_by_way      (valid_by_way),
    .first_idx_by_way  (first_idx_by_way),
    .second_idx_by_way (second_idx_by_way)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: walk a parcel pointer, jumping by the instruction length.
  function automatic exp_t model(input logic [15:0] v, input logic [15:0] u, input logic [15:0] r);
    exp_t e;
    logic [16:0] vx;
    int i;
    int n;
    logic cpl;
    e.cnt    = '0;
    e.deq    = '0;
    e.vbw    = '0;
    e.first  = '1;
    e.second = '1;
    vx = {1'b0, v};
    i = 0;
    n = 0;
    while (i < 16) begin
      if (!v[i]) begin
        e.cnt[i] = 5'(n);
        i = i + 1;
      end else begin
        cpl = !u[i] || vx[i+1] || r[i];
        if (cpl) n = n + 1;
        e.cnt[i] = 5'(n);
        if (u[i] && i < 15) e.cnt[i+1] = 5'(n);
        if (cpl && n <= 4) begin
          e.vbw[n-1]    = 1'b1;
          e.first[n-1]  = 4'(i);
          e.second[n-1] = (i < 15) ? 4'(i + 1) : 4'hf;
          e.deq[i]      = 1'b1;
          if (u[i] && vx[i+1]) e.deq[i+1] = 1'b1;
        end
        i = i + (u[i] ? 2 : 1);
      end
    end
    return e;
  endfunction

  // driver: apply one pattern and queue its expected outputs
  task automatic drive(input logic [15:0] v, input logic [15:0] u, input logic [15:0] r);
    @(posedge CLK);
    valid_vec        = v;
    uncompressed_vec = u;
    redirect_vec     = r;
    exp_q.push_back(model(v, u, r));
  endtask

  // scoreboard: pop and compare every output field
  task automatic score(input string tag);
    exp_t e;
    @(negedge CLK);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue got empty exp entry", tag);
    end else begin
      checks--;
      e = exp_q.pop_front();
      check_eq({tag, "_count"},  80'(count_vec),         80'(e.cnt));
      check_eq({tag, "_deq"},    80'(deqing_vec),        80'(e.deq));
      check_eq({tag, "_vbw"},    80'(valid_by_way),      80'(e.vbw));
      check_eq({tag, "_first"},  80'(first_idx_by_way),  80'(e.first));
      check_eq({tag, "_second"}, 80'(second_idx_by_way), 80'(e.second));
    end
  endtask

  // Hand-derived results for the named patterns, independent of the model.
  task automatic directed(input string tag, input logic [15:0] v, input logic [15:0] u,
                          input logic [15:0] r, input logic [15:0] deq, input logic [3:0] vbw,
                          input logic [15:0] first, input logic [4:0] cnt15);
    drive(v, u, r);
    score(tag);
    check_eq({tag, "_k_deq"},   80'(deqing_vec),       80'(deq));
    check_eq({tag, "_k_vbw"},   80'(valid_by_way),     80'(vbw));
    check_eq({tag, "_k_first"}, 80'(first_idx_by_way), 80'(first));
    check_eq({tag, "_k_cnt15"}, 80'(count_vec[15]),    80'(cnt15));
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] u;
    logic [15:0] r;
    logic [79:0] ramp;
    nRST             = 1'b0;
    valid_vec        = '0;
    uncompressed_vec = '0;
    redirect_vec     = '0;

    // outputs are idle while reset is asserted
    drive(16'h0, 16'h0, 16'h0);
    score("reset");
    check_eq("reset_second", 80'(second_idx_by_way), 80'hffff);
    @(posedge CLK);
    nRST = 1'b1;

    directed("idle",     16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 16'hffff, 5'd0);
    directed("all_c",    16'hffff, 16'h0000, 16'h0000, 16'h000f, 4'hf, 16'h3210, 5'd16);
    ramp = '0;
    for (int i = 0; i < 16; i++) ramp[i*5 +: 5] = 5'(i + 1);
    check_eq("all_c_ramp", 80'(count_vec), ramp);
    check_eq("all_c_second", 80'(second_idx_by_way), 80'h4321);
    directed("all_u",    16'hffff, 16'hffff, 16'h0000, 16'h00ff, 4'hf, 16'h6420, 5'd8);
    check_eq("all_u_second", 80'(second_idx_by_way), 80'h7531);
    directed("u5555",    16'hffff, 16'h5555, 16'h0000, 16'h00ff, 4'hf, 16'h6420, 5'd8);
    directed("uaaaa",    16'hffff, 16'haaaa, 16'h0000, 16'h007f, 4'hf, 16'h5310, 5'd8);
    check_eq("uaaaa_second", 80'(second_idx_by_way), 80'h6421);
    check_eq("uaaaa_cnt1",   80'(count_vec[1]), 80'd2);
    directed("lone",     16'h00f0, 16'h0080, 16'h0000, 16'h0070, 4'h7, 16'hf654, 5'd3);
    directed("lone_rd",  16'h00f0, 16'h0080, 16'h0080, 16'h00f0, 4'hf, 16'h7654, 5'd4);
    check_eq("lone_rd_second", 80'(second_idx_by_way), 80'h8765);
    directed("tail",     16'h81e0, 16'h8080, 16'h0000, 16'h01e0, 4'h7, 16'hf765, 5'd3);
    directed("tail_rd",  16'h81e0, 16'h8080, 16'h8000, 16'h81e0, 4'hf, 16'hf765, 5'd4);
    check_eq("tail_rd_way3_second", 80'(second_idx_by_way[3]), 80'hf);
    directed("tail_c",   16'h81e0, 16'h0080, 16'h0000, 16'h81e0, 4'hf, 16'hf765, 5'd4);

    // random patterns with mixed densities; sparse redirect markers
    for (int n = 0; n < 300; n++) begin
      v = 16'($urandom_range(0, 65535));
      if (n % 3 == 0) v = v | 16'($urandom_range(0, 65535));
      u = 16'($urandom_range(0, 65535));
      r = 16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535)) &
          16'($urandom_range(0, 65535));
      drive(v, u, r);
      score("rand");
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
